// File: rtl/inst_loader.sv
// Boot-time program loader: receives a 4-byte little-endian word-count header
// followed by the image bytes, assembles little-endian words and writes them to
// instruction memory at consecutive word addresses. The CPU is held in reset
// until the whole image has been written. Oversized images latch a sticky error.
//
// state | meaning
// HDR   | collecting the 4-byte word-count header
// DATA  | assembling and writing image words
// DONE  | image complete, CPU released, input ignored
// ERR   | header count exceeds capacity, CPU held, input ignored
module inst_loader #(
    parameter int ADDR_WIDTH = 15,
    parameter int HDR_BYTES  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH-2:0] words_written,
    output logic                  cpu_reset_n,
    output logic                  done,
    output logic                  error
);

    localparam logic [1:0] HDR  = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam logic [31:0] CAPACITY = 32'd1 << (ADDR_WIDTH - 2);

    logic [1:0]  state;
    logic [1:0]  byte_idx;
    logic [31:0] shift_reg;
    logic [31:0] n_words;
    logic [31:0] word_buf;
    logic        wr_pend;
    logic        last_pend;
    logic        fin_pend;

    logic [31:0] next_word;
    logic [31:0] ww_next;

    // Word completed by the byte arriving this cycle, and the count after the pending write.
    always_comb begin
        next_word = {rx_data, shift_reg[31:8]};
        ww_next   = 32'(words_written) + 32'd1;
    end

    // Loader sequencing: header capture, word assembly, delayed write and completion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= HDR;
            byte_idx      <= 2'd0;
            shift_reg     <= 32'd0;
            n_words       <= 32'd0;
            word_buf      <= 32'd0;
            wr_pend       <= 1'b0;
            last_pend     <= 1'b0;
            fin_pend      <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= 32'd0;
            words_written <= '0;
            cpu_reset_n   <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            mem_we <= 1'b0;

            // The write lands one cycle after the word's last byte; the index is
            // taken from words_written so it never needs to wrap past capacity.
            if (wr_pend) begin
                mem_we        <= 1'b1;
                mem_addr      <= {words_written[ADDR_WIDTH-3:0], 2'b00};
                mem_wdata     <= word_buf;
                words_written <= words_written + 1'b1;
                wr_pend       <= 1'b0;
                fin_pend      <= last_pend;
            end

            case (state)
                HDR: begin
                    if (rx_valid) begin
                        shift_reg <= next_word;
                        byte_idx  <= byte_idx + 2'd1;
                        if (byte_idx == 2'(HDR_BYTES - 1)) begin
                            n_words <= next_word;
                            if (next_word == 32'd0) begin
                                state       <= DONE;
                                done        <= 1'b1;
                                cpu_reset_n <= 1'b1;
                            end else if (next_word > CAPACITY) begin
                                state <= ERR;
                                error <= 1'b1;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    // Bytes after the final word are not assembled.
                    if (rx_valid && !last_pend) begin
                        shift_reg <= next_word;
                        byte_idx  <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            word_buf  <= next_word;
                            wr_pend   <= 1'b1;
                            last_pend <= (ww_next == n_words);
                        end
                    end
                    if (fin_pend) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        cpu_reset_n <= 1'b1;
                        fin_pend    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a write scoreboard: stimulus pushes the
// expected memory writes, an independent monitor pops and compares them.
module tb_inst_loader;

    localparam int AW = 15;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] ww;
    } wr_t;

    logic          clk;
    logic          reset_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW-2:0] words_written;
    logic          cpu_reset_n;
    logic          done;
    logic          error;

    int  checks = 0;
    int  errors = 0;
    int  gcnt   = 0;
    wr_t exp_q[$];
    logic prev_we = 1'b0;

    inst_loader #(.ADDR_WIDTH(AW), .HDR_BYTES(4)) dut (
        .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .words_written(words_written), .cpu_reset_n(cpu_reset_n),
        .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_we) begin
            checks++;
            if (prev_we) begin
                errors++;
                $display("FAIL we_width: mem_we high two cycles in a row at addr %h", mem_addr);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (32'(mem_addr) != e.addr || mem_wdata != e.data || 32'(words_written) != e.ww) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h ww %0d, expected addr %h data %h ww %0d",
                             mem_addr, mem_wdata, words_written, e.addr, e.data, e.ww);
                end
            end
        end
        prev_we = mem_we;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic send_word_gappy(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gcnt % 6);
            gcnt++;
        end
    endtask

    task automatic expect_wr(input int k, input logic [31:0] d);
        wr_t e;
        e.addr = 32'(k * 4);
        e.data = d;
        e.ww   = 32'(k + 1);
        exp_q.push_back(e);
    endtask

    task automatic check_queue_empty(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(mem_we), 32'd0);
        check({tag, "_addr"},  32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_ww"},    32'(words_written), 32'd0);
        check({tag, "_cpurst"},32'(cpu_reset_n), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_err"},   32'(error), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Two-word image, one byte per cycle.
        send_word(32'd2, 0);
        expect_wr(0, 32'h0000_0013);
        expect_wr(1, 32'h0000_10B7);
        send_word(32'h0000_0013, 0);
        send_word(32'h0000_10B7, 0);
        check("t1_done_t", 32'(done), 32'd0);
        @(negedge clk);
        check("t1_done_t1", 32'(done), 32'd0);
        @(negedge clk);
        check("t1_done_t2", 32'(done), 32'd1);
        check("t1_cpurst", 32'(cpu_reset_n), 32'd1);
        check("t1_ww", 32'(words_written), 32'd2);
        check_queue_empty("t1_q");

        // Bytes after done are ignored.
        send_word(32'hDEAD_BEEF, 0);
        send_word(32'h1234_5678, 1);
        check("t1x_done", 32'(done), 32'd1);
        check("t1x_ww", 32'(words_written), 32'd2);
        check("t1x_addr", 32'(mem_addr), 32'h4);
        check("t1x_data", mem_wdata, 32'h0000_10B7);

        // Same image with 0..5 idle cycles between strobes.
        do_reset();
        check_all_zero("rst2");
        send_word_gappy(32'd2);
        expect_wr(0, 32'h0000_0013);
        expect_wr(1, 32'h0000_10B7);
        send_word_gappy(32'h0000_0013);
        send_word_gappy(32'h0000_10B7);
        repeat (3) @(negedge clk);
        check("t2_done", 32'(done), 32'd1);
        check("t2_ww", 32'(words_written), 32'd2);
        check_queue_empty("t2_q");

        // Empty image.
        do_reset();
        send_word(32'd0, 0);
        check("t3_done", 32'(done), 32'd1);
        check("t3_cpurst", 32'(cpu_reset_n), 32'd1);
        send_word(32'h0403_0201, 0);
        repeat (2) @(negedge clk);
        check("t3_ww", 32'(words_written), 32'd0);
        check("t3_err", 32'(error), 32'd0);

        // Oversized image: 8193 words.
        do_reset();
        send_word(32'h0000_2001, 0);
        check("t4_err", 32'(error), 32'd1);
        check("t4_done", 32'(done), 32'd0);
        check("t4_cpurst", 32'(cpu_reset_n), 32'd0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0000_0013, 2);
        check("t4x_err", 32'(error), 32'd1);
        check("t4x_cpurst", 32'(cpu_reset_n), 32'd0);
        check("t4x_ww", 32'(words_written), 32'd0);

        // Reset in the middle of a three-word load, then a fresh one-word load.
        do_reset();
        send_word(32'd3, 0);
        expect_wr(0, 32'h4433_2211);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
        check_queue_empty("t5_q");
        check("t5_ww_pre", 32'(words_written), 32'd1);
        do_reset();
        check_all_zero("t5rst");
        send_word(32'd1, 0);
        expect_wr(0, 32'hDDCC_BBAA);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
        repeat (2) @(negedge clk);
        check("t5_done", 32'(done), 32'd1);
        check("t5_ww", 32'(words_written), 32'd1);
        check_queue_empty("t5_q2");

        // Full-capacity image: 8192 words.
        do_reset();
        send_word(32'h0000_2000, 0);
        for (int i = 0; i < 8192; i++) begin
            logic [31:0] d;
            d = {16'hC0DE ^ 16'(i), 16'(i)};
            expect_wr(i, d);
            send_word(d, 0);
        end
        repeat (2) @(negedge clk);
        check("t6_done", 32'(done), 32'd1);
        check("t6_err", 32'(error), 32'd0);
        check("t6_addr", 32'(mem_addr), 32'h7FFC);
        check("t6_ww", 32'(words_written), 32'd8192);
        check_queue_empty("t6_q");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Boot-time program loader: the writer side of the instruction ROM.
- Takes a byte stream from the UART receiver and assembles little-endian 32-bit words.
- Writes each word into instruction memory at consecutive word-aligned byte addresses.
- Holds the CPU in reset until the image is complete. An error (oversized image) is flagged and sticky until reset.

Parameters:
ADDR_WIDTH, 15, instruction-memory byte-address width; capacity = 2^(ADDR_WIDTH-2) words
HDR_BYTES, 4, length of the word-count header in bytes (fixed at 4, little-endian)

Ports:
clk  input  1  clock
reset_n  input  1  reset, synchronous, active-low
rx_valid  input  1  one-cycle strobe: rx_data holds a new byte; no backpressure, loader always accepts
rx_data  input  8  received byte
mem_we  output  1  one-cycle write strobe to instruction memory
mem_addr  output  ADDR_WIDTH  byte address of write; bits [1:0] always 0
mem_wdata  output  32  word to write
words_written  output  ADDR_WIDTH-1  count of words written so far
cpu_reset_n  output  1  low while loading; high once load completes
done  output  1  load complete (sticky)
error  output  1  header count exceeds capacity (sticky)

Behaviour:
- Reset (reset_n low at posedge clk):
  - All outputs go to 0, which keeps cpu_reset_n low.
  - State goes to HDR; byte index, word index, word count and assembly register are cleared.
  - Reset mid-load aborts the load. Memory contents are not touched; the next load overwrites them.
- States: HDR, DATA, DONE, ERR.
- HDR:
  - Each rx_valid byte shifts into the count register, little-endian (first byte = bits [7:0]).
  - On the 4th header byte, at that posedge:
    - N == 0 -> DONE.
    - N > 2^(ADDR_WIDTH-2) -> ERR.
    - Otherwise -> DATA with word index 0.
  - N is 32 bits; the comparison uses the full width, with no truncation.
- DATA:
  - Bytes are assembled little-endian; a 2-bit byte counter wraps 3->0.
  - If the 4th byte of word k is accepted at posedge t, then at posedge t+1: mem_we=1, mem_addr = k*4, mem_wdata = assembled word, words_written = k+1.
  - mem_we is high for exactly one cycle per word. mem_addr and mem_wdata hold their values until the next write.
  - Back-to-back rx_valid on every cycle is supported: one write per 4 cycles, no byte is dropped.
  - After the write of word N-1: done=1 and cpu_reset_n=1 on the following cycle (posedge t+2); state goes to DONE.
- DONE: rx_valid is ignored; no further writes; done and cpu_reset_n stay 1 until reset.
- ERR: error=1 from the cycle after the 4th header byte; cpu_reset_n stays 0; rx_valid ignored; no writes are ever issued.
- done and error are never both 1.
- Partial bytes: there is no timeout. The loader waits indefinitely, and a partial word is never written.
- Boundaries:
  - N == capacity is legal. The last write goes to address (capacity-1)*4, and the word index does not wrap.
  - words_written saturates at N.

Test Plan:
- Header 02 00 00 00, then bytes 13 00 00 00 B7 10 00 00 at one byte per cycle -> mem_we pulses twice: (addr 0x0000, data 0x00000013) and (addr 0x0004, data 0x000010B7). done and cpu_reset_n rise 1 cycle after the 2nd pulse; words_written=2.
- Header 00 00 00 00 -> done=1 the cycle after the 4th byte; no mem_we ever; extra bytes ignored.
- With ADDR_WIDTH=15: header 01 20 00 00 (8193 > 8192) -> error=1, cpu_reset_n stays 0, no writes. Header 00 20 00 00 (8192) -> load runs; final write at addr 0x7FFC; done=1.
- Bytes with gaps of 0-5 idle cycles between rx_valid strobes -> same writes and data as the gap-free case; each mem_we is exactly one cycle long.
- reset_n low for 1 cycle after 6 data bytes of a 3-word load -> all outputs 0. A fresh header 01 00 00 00 + AA BB CC DD -> single write of addr 0, data 0xDDCCBBAA; then done=1.
- Bytes sent after done or error -> no mem_we, and outputs are unchanged.
